i2c_master_arbiter: RTL and testbench

//  Shares one i2c_master between N_REQ requesters (sensor pollers, config loaders).

---
 rtl/i2c_master_arbiter.sv | 125 ++++++++++++
 tb/tb_i2c_master_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin sharing of one i2c_master among N_REQ requesters,
// latching the winner's command and returning rdata plus a done/err pulse.
module i2c_master_arbiter #(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [7*N_REQ-1:0] req_addr,
    input  logic [N_REQ-1:0]   req_rw,
    input  logic [8*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [N_REQ-1:0]   err,
    output logic [7:0]         rdata,
    output logic               m_start,
    output logic [6:0]         m_addr,
    output logic               m_rw,
    output logic [7:0]         m_data_in,
    input  logic [7:0]         m_data_out,
    input  logic               m_busy
);
    localparam int PW = $clog2(N_REQ);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LAUNCH    = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] COMPLETE  = 3'd4;

    logic [2:0]    state;
    logic [PW-1:0] rr_ptr, win, idx;
    logic [TW-1:0] tmo_cnt;
    logic          hit;
    logic [6:0]    sel_addr;
    logic          sel_rw;
    logic [7:0]    sel_wdata;

    // Scan from farthest to nearest so the requester closest after rr_ptr wins.
    always_comb begin
        win = rr_ptr;
        hit = 1'b0;
        idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = PW'((int'(rr_ptr) + k) % N_REQ);
            if (req[idx]) begin
                win = idx;
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_rw    = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == PW'(i)) begin
                sel_addr  = req_addr[7*i +: 7];
                sel_rw    = req_rw[i];
                sel_wdata = req_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rr_ptr    <= PW'(N_REQ - 1);
            tmo_cnt   <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= '0;
            rdata     <= '0;
            m_start   <= 1'b0;
            m_addr    <= '0;
            m_rw      <= 1'b0;
            m_data_in <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit && !m_busy) begin
                        gnt       <= N_REQ'(1) << win;
                        m_start   <= 1'b1;
                        m_addr    <= sel_addr;
                        m_rw      <= sel_rw;
                        m_data_in <= sel_wdata;
                        rr_ptr    <= win;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    m_start <= 1'b0;
                    tmo_cnt <= '0;
                    state   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (m_busy) begin
                        state <= WAIT_DONE;
                    end else if (tmo_cnt >= TW'(BUSY_TIMEOUT - 1)) begin
                        err   <= gnt;
                        state <= COMPLETE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!m_busy) begin
                        if (m_rw) rdata <= m_data_out;
                        done  <= gnt;
                        state <= COMPLETE;
                    end
                end
                COMPLETE: begin
                    gnt   <= '0;
                    done  <= '0;
                    err   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb_i2c_master_arbiter: scoreboard bench for i2c_master_arbiter with a simple i2c_master busy model.
module tb_i2c_master_arbiter;
    localparam int TMO = 16;

    logic        clk, reset_n;
    logic [3:0]  req, req_rw, gnt, done, err;
    logic [27:0] req_addr;
    logic [31:0] req_wdata;
    logic [7:0]  rdata, m_data_in, m_data_out;
    logic        m_start, m_rw, m_busy, mdl_busy, ext_busy, model_en;
    logic [6:0]  m_addr;

    typedef struct {
        int         kind;
        logic [3:0] g;
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wd;
        logic [7:0] rd;
        int         lat;
    } exp_t;

    exp_t       q[$];
    exp_t       me;
    int         tests = 0, fails = 0, cyc = 0, req_cyc = 0, launch_cyc = 0, busy_len = 3;
    bit         chk_start = 0;
    logic [7:0] rd_model = 8'h00, model_rdata = 8'h00;
    logic [6:0] a_tab [4];
    logic [7:0] w_tab [4];
    logic       rw_tab [4];

    assign m_busy = mdl_busy | ext_busy;

    i2c_master_arbiter #(.N_REQ(4), .BUSY_TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr), .req_rw(req_rw),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
        .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw), .m_data_in(m_data_in),
        .m_data_out(m_data_out), .m_busy(m_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Master model: busy rises the cycle after m_start and lasts busy_len cycles.
    initial begin
        mdl_busy = 1'b0;
        m_data_out = 8'h00;
        forever begin
            @(negedge clk);
            if (m_start && model_en && reset_n) begin
                @(posedge clk);
                #1 mdl_busy = 1'b1;
                m_data_out = 8'h00;
                repeat (busy_len) @(posedge clk);
                #1 m_data_out = model_rdata;
                mdl_busy = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            if (chk_start) begin
                chk("start_pulse", 64'(m_start), 64'(0));
                chk_start = 0;
            end
            if (m_start) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_start: gnt=%b with nothing expected", gnt);
                end else begin
                    me = q.pop_front();
                    chk("launch_kind", 64'(0), 64'(me.kind));
                    chk("launch_gnt", 64'(gnt), 64'(me.g));
                    chk("launch_addr", 64'(m_addr), 64'(me.addr));
                    chk("launch_rw", 64'(m_rw), 64'(me.rw));
                    chk("launch_wdata", 64'(m_data_in), 64'(me.wd));
                    chk("launch_rdata", 64'(rdata), 64'(me.rd));
                    if (me.lat > 0) chk("launch_lat", 64'(cyc - req_cyc), 64'(me.lat));
                    launch_cyc = cyc;
                    chk_start = 1;
                end
            end
            if (|done || |err) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_end: done=%b err=%b with nothing expected", done, err);
                end else begin
                    me = q.pop_front();
                    chk("end_kind", 64'(|done ? 1 : 2), 64'(me.kind));
                    chk("end_done", 64'(done), 64'(me.kind == 1 ? me.g : 4'b0));
                    chk("end_err", 64'(err), 64'(me.kind == 2 ? me.g : 4'b0));
                    chk("end_gnt", 64'(gnt), 64'(me.g));
                    chk("end_addr", 64'(m_addr), 64'(me.addr));
                    chk("end_rdata", 64'(rdata), 64'(me.rd));
                    chk("end_lat", 64'(cyc - launch_cyc), 64'(me.lat));
                end
            end
        end
    end

    task automatic load_fields();
        for (int i = 0; i < 4; i++) begin
            req_addr[7*i +: 7]  = a_tab[i];
            req_wdata[8*i +: 8] = w_tab[i];
            req_rw[i]           = rw_tab[i];
        end
    endtask

    task automatic push_txn(input int i, input bit to_err, input bit abort, input int llat, input int clat);
        exp_t e;
        e.kind = 0;
        e.g    = 4'(1 << i);
        e.addr = a_tab[i];
        e.rw   = rw_tab[i];
        e.wd   = w_tab[i];
        e.rd   = rd_model;
        e.lat  = llat;
        q.push_back(e);
        if (!abort) begin
            if (rw_tab[i] && !to_err) rd_model = model_rdata;
            e.kind = to_err ? 2 : 1;
            e.rd   = rd_model;
            e.lat  = clat;
            q.push_back(e);
        end
    endtask

    task automatic go(input logic [3:0] r);
        @(posedge clk);
        #1 req = r;
        req_cyc = cyc;
    endtask

    task automatic wait_empty(input int limit);
        int n = 0;
        while (q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL wait_empty: %0d expected events still pending after %0d cycles", q.size(), limit);
            q.delete();
        end
    endtask

    task automatic check_reset_outs();
        chk("rst_gnt_done_err", 64'({gnt, done, err}), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        chk("rst_m_outs", 64'({m_start, m_addr, m_rw, m_data_in}), 64'(0));
    endtask

    initial begin
        reset_n = 1'b0;
        req = '0;
        ext_busy = 1'b0;
        model_en = 1'b1;
        a_tab = '{7'h50, 7'h21, 7'h32, 7'h43};
        w_tab = '{8'hA5, 8'h11, 8'h22, 8'h33};
        rw_tab = '{1'b0, 1'b0, 1'b0, 1'b0};
        load_fields();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outs();
        @(posedge clk);
        #1 reset_n = 1'b1;

        // All four held: first grant goes to 0, then strict rotation.
        busy_len = 3;
        push_txn(0, 0, 0, 1, 5);
        push_txn(1, 0, 0, 0, 5);
        push_txn(2, 0, 0, 0, 5);
        push_txn(3, 0, 0, 0, 5);
        push_txn(0, 0, 0, 0, 5);
        go(4'b1111);
        wait_empty(300);
        #1 req = '0;

        // Single write with long busy; req and fields change mid-flight.
        busy_len = 40;
        push_txn(0, 0, 0, 1, 42);
        go(4'b0001);
        repeat (3) @(posedge clk);
        #1 req = '0;
        req_addr[6:0] = 7'h11;
        req_wdata[7:0] = 8'h00;
        wait_empty(300);
        load_fields();

        // Read on requester 2, then a write that must leave rdata alone.
        busy_len = 4;
        rw_tab[2] = 1'b1;
        load_fields();
        model_rdata = 8'h3C;
        push_txn(2, 0, 0, 1, 6);
        go(4'b0100);
        wait_empty(300);
        #1 req = '0;
        rw_tab[2] = 1'b0;
        load_fields();
        model_rdata = 8'h77;
        push_txn(1, 0, 0, 1, 6);
        go(4'b0010);
        wait_empty(300);
        #1 req = '0;

        // Master never answers: err after the full WAIT_BUSY window, then next request served.
        model_en = 1'b0;
        push_txn(0, 1, 0, 1, TMO + 1);
        go(4'b0001);
        wait_empty(300);
        #1 req = '0;
        model_en = 1'b1;
        push_txn(3, 0, 0, 1, 6);
        go(4'b1000);
        wait_empty(300);
        #1 req = '0;

        // Master busy in IDLE blocks arbitration.
        @(posedge clk);
        #1 ext_busy = 1'b1;
        push_txn(2, 0, 0, 1, 6);
        go(4'b0100);
        repeat (6) begin
            @(negedge clk);
            chk("busy_hold_gnt", 64'({gnt, m_start}), 64'(0));
        end
        @(posedge clk);
        #1 ext_busy = 1'b0;
        req_cyc = cyc;
        wait_empty(300);
        #1 req = '0;

        // Reset during WAIT_DONE abandons the transfer and restarts the rotation at 0.
        busy_len = 20;
        push_txn(0, 0, 1, 1, 0);
        go(4'b0001);
        wait_empty(300);
        repeat (6) @(posedge clk);
        #1 reset_n = 1'b0;
        req = '0;
        #1 check_reset_outs();
        begin
            int n = 0;
            while (mdl_busy && n < 100) begin
                @(posedge clk);
                n++;
            end
            chk("model_idle", 64'(mdl_busy), 64'(0));
        end
        rd_model = 8'h00;
        busy_len = 3;
        push_txn(0, 0, 0, 1, 5);
        push_txn(1, 0, 0, 0, 5);
        req = 4'b0011;
        @(posedge clk);
        #1 reset_n = 1'b1;
        req_cyc = cyc;
        wait_empty(300);
        #1 req = '0;
        repeat (5) @(posedge clk);
        wait_empty(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
